// File: rtl/custom_stream_v2_0_pkg.sv
// Shared types and constants for the custom-stream v2 buffer.
package custom_stream_v2_0_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } ingress_state_t;

  // Stored entry is {fs, user, addr, data}.
  function automatic int unsigned entry_width(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

// File: rtl/custom_stream_v2_0_fifo.sv
// Synchronous FIFO: registered wrap-bit pointers, combinational read data.
module custom_stream_v2_0_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/custom_stream_v2_0_buffer.sv
// v1 push stream to v2 valid/ready stream with frame alignment, tail dropping
// on overflow, and frame/drop statistics.
module custom_stream_v2_0_buffer
  import custom_stream_v2_0_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              cs_clk,
  input  logic              cs_rst,
  input  logic              s_valid,
  input  logic              s_fs,
  input  logic              s_user,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_fs,
  output logic              m_user,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef struct packed {
    logic              fs;
    logic              user;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int unsigned EW = entry_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ingress_state_t state;
  ingress_state_t state_next;
  entry_t         wr_entry;
  logic [EW-1:0]  head_raw;
  entry_t         head;
  logic           full;
  logic           empty;
  logic           wr_en;
  logic           drop;
  logic           pop;

  assign wr_entry = '{fs: s_fs, user: s_user, addr: s_addr, data: s_data};
  assign head     = entry_t'(head_raw);

  custom_stream_v2_0_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (cs_clk),
    .rst     (cs_rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_raw),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge cs_clk or posedge cs_rst) begin
    if (cs_rst) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SYNC: if (s_valid && s_fs && !full) state_next = PASS;
      PASS: if (s_valid && full)          state_next = DROP;
      DROP: if (s_valid && s_fs && !full) state_next = PASS;
      default:                            state_next = SYNC;
    endcase
  end

  // Words seen in SYNC vanish silently; only PASS/DROP losses are counted.
  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    unique case (state)
      SYNC: wr_en = s_valid & s_fs & ~full;
      PASS: begin
        wr_en = s_valid & ~full;
        drop  = s_valid & full;
      end
      DROP: begin
        wr_en = s_valid & s_fs & ~full;
        drop  = s_valid & ~(s_fs & ~full);
      end
      default: ;
    endcase
  end

  // Egress fields are zeroed whenever nothing is presented.
  assign m_valid = ~empty;
  assign m_fs    = m_valid & head.fs;
  assign m_user  = m_valid & head.user;
  assign m_addr  = m_valid ? head.addr : '0;
  assign m_data  = m_valid ? head.data : '0;
  assign pop     = m_valid & m_ready;

  // A drop coinciding with a clear wins: the count restarts at one.
  always_ff @(posedge cs_clk or posedge cs_rst) begin
    if (cs_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                  drop_cnt <= CNT_W'(1);
      else if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_ff @(posedge cs_clk or posedge cs_rst) begin
    if (cs_rst)              frame_cnt <= '0;
    else if (pop && head.fs) frame_cnt <= frame_cnt + CNT_W'(1);
  end

endmodule

// File: doc/custom_stream_v2_0_buffer.md
# custom_stream_v2_0_buffer

Parametrised second-generation custom-stream stage: accepts a v1-style push stream (address, data, frame sync, user) with a word qualifier, buffers it in a DEPTH-entry FIFO, and re-emits it as a v2 stream with valid/ready backpressure. The block adds what v1 lacks:
- frame alignment after reset;
- whole-frame-tail dropping on overflow;
- frame and drop statistics.

It sits between any free-running cs producer and a consumer that can stall.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 16, FIFO entries; power of two, ≥ 4
- CNT_W, 16, width of statistics counters

Ports:
- cs_clk  in  1  clock; single clock domain
- cs_rst  in  1  reset; asynchronous, active-high
- s_valid  in  1  input word qualifier
- s_fs  in  1  frame sync; marks first word of a frame
- s_user  in  1  user signalling bit, carried with the word
- s_addr  in  ADDR_W  word address
- s_data  in  DATA_W  word data
- m_valid  out  1  output word available
- m_ready  in  1  consumer accepts word
- m_fs, m_user, m_addr, m_data  out  1/1/ADDR_W/DATA_W  output word fields
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one word dropped since last clear
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt
- drop_cnt  out  CNT_W  dropped-word count, saturating
- frame_cnt  out  CNT_W  frames emitted (m_fs handshakes), wrapping

## Operation
- Stored entry is {fs, user, addr, data}. Input has no backpressure; a word is either written or dropped in the cycle s_valid is high.
- Ingress FSM (state held in package enum):
  - SYNC (reset state): discard every word. On s_valid & s_fs & !full, write the word and go to PASS. Words discarded in SYNC are not counted and do not set overflow.
  - PASS: on s_valid & !full, write the word. On s_valid & full, drop the word, set overflow, increment drop_cnt, and go to DROP.
  - DROP: on s_valid, drop and count the word, unless s_fs & !full. In that case write the word and go to PASS. An fs word arriving while still full stays in DROP and is counted.
- full and empty derive from registered pointers only. A read in the same cycle does not free a slot for a same-cycle write: a write arriving when full is dropped even if m_ready & m_valid.
- Egress:
  - m_valid = !empty.
  - m_* come combinationally from the entry at the read pointer and are forced to 0 when m_valid is low.
  - A word is consumed on m_valid & m_ready.
  - Data may change only after a handshake.
- level = write pointer minus read pointer. Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full = (level == DEPTH).
- frame_cnt increments on m_valid & m_ready & m_fs.
- drop_cnt saturates at all-ones.
- clr_ovf clears overflow and drop_cnt to 0 on the next edge. If a drop occurs in the same cycle as clr_ovf, the drop wins: overflow = 1 and drop_cnt = 1.

## Timing
- Reset values (asynchronous): state SYNC, pointers 0, level 0, m_valid 0, all m_* fields 0, overflow 0, drop_cnt 0, frame_cnt 0. Memory contents are not reset.
- Latency: word written at edge N is presented with m_valid = 1 in cycle N+1 (one cycle, input to output).
- Throughput: one word per cycle sustained when m_ready is held high.
- Reset asserted mid-frame flushes the FIFO. Ingress then realigns on the next s_fs.
- level updates one cycle after the write/read edge. Simultaneous write and read leave level unchanged.

## Structure
- Package custom_stream_v2_0_pkg:
  - ingress state enum {SYNC, PASS, DROP};
  - parametrised entry struct typedef pattern (fs, user, addr, data);
  - default CNT_W constant.
- Sub-module custom_stream_v2_0_fifo: synchronous FIFO with registered pointers, full/empty/level outputs, and combinational read data.
- Top-level custom_stream_v2_0_buffer holds the ingress FSM, the drop logic, and the statistics counters.

## Test plan
- Alignment: after reset, push 3 words without fs, then a frame of 4 words starting with s_fs. Only the 4 words appear. The first has m_fs = 1. frame_cnt = 1, drop_cnt = 0.
- Backpressure: DEPTH = 16, m_ready = 0, push a 16-word frame. level = 16 and no drop. Then raise m_ready: all 16 words come out in order on consecutive cycles.
- Overflow: m_ready = 0, push a 20-word frame, then a new fs frame of 2 words after draining 4 words:
  - words 17–20 are dropped, overflow = 1, drop_cnt = 4;
  - the FSM stays in DROP until the fs word, and the new frame is emitted intact.
- Full with simultaneous read: level = 16, m_ready = 1, s_valid = 1. The input word is dropped and drop_cnt increments; next cycle level = 15.
- Counter boundaries:
  - CNT_W = 4, force 20 drops: drop_cnt holds 15.
  - Emit 17 frames: frame_cnt = 1.
  - clr_ovf coincident with a drop yields drop_cnt = 1, overflow = 1.
- Reset mid-frame: assert cs_rst with level = 7. Next cycle m_valid = 0, level = 0, state SYNC; words without fs are discarded.
